// File: rtl/mm3_dot_sequencer.sv
// mm3_dot_sequencer: walks the nine {row,col} indices produced by an external
// 3x3 index counter, computes C[row][col] = sum_k A[row][k]*B[k][col] with a
// three-cycle multiply-accumulate, stores it into an internal C bank and
// requests the next index with a one-cycle count-enable (adv).
// Optional feature macro: MM3_SIGNED_EN (two's complement operands/results).
module mm3_dot_sequencer #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+2
) (
  input  logic                 clk,
  input  logic                 mr,
  input  logic                 start,
  input  logic [3:0]           idx,
  input  logic [9*WIDTH-1:0]   a_flat,
  input  logic [9*WIDTH-1:0]   b_flat,
  output logic                 adv,
  output logic [9*ACC_W-1:0]   c_flat,
  output logic                 c_we,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_WRITE = 3'd2,
    ST_ADV   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'b1010;

  // Linear element position (3*r + c) inside the packed 3x3 matrices.
  function automatic logic [3:0] elem_pos(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} * 4'd3) + {2'b00, c};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [1:0]         k_r;
  logic [1:0]         k_nxt_s;
  logic [1:0]         row_r;
  logic [1:0]         col_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   c_arr_r [9];

  logic [WIDTH-1:0]   a_arr_s [9];
  logic [WIDTH-1:0]   b_arr_s [9];
  logic [1:0]         row_s;
  logic [1:0]         col_s;
  logic               op_ok_s;
  logic [3:0]         a_pos_s;
  logic [3:0]         b_pos_s;
  logic [WIDTH-1:0]   a_el_s;
  logic [WIDTH-1:0]   b_el_s;
  logic [2*WIDTH-1:0] a_ext_s;
  logic [2*WIDTH-1:0] b_ext_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [ACC_W-1:0]   prod_ext_s;

  for (genvar gi = 0; gi < 9; gi++) begin : g_bank
    assign a_arr_s[gi] = a_flat[gi*WIDTH +: WIDTH];
    assign b_arr_s[gi] = b_flat[gi*WIDTH +: WIDTH];
    assign c_flat[gi*ACC_W +: ACC_W] = c_arr_r[gi];
  end

  // The k==0 MAC cycle is where idx is sampled; later k steps use the captured row/col.
  assign row_s   = (k_r == 2'd0) ? idx[3:2] : row_r;
  assign col_s   = (k_r == 2'd0) ? idx[1:0] : col_r;
  assign op_ok_s = (row_s != 2'd3) && (col_s != 2'd3);
  assign a_pos_s = op_ok_s ? elem_pos(row_s, k_r) : 4'd0;
  assign b_pos_s = op_ok_s ? elem_pos(k_r, col_s) : 4'd0;
  assign a_el_s  = a_arr_s[a_pos_s];
  assign b_el_s  = b_arr_s[b_pos_s];

`ifdef MM3_SIGNED_EN
  assign a_ext_s    = {{WIDTH{a_el_s[WIDTH-1]}}, a_el_s};
  assign b_ext_s    = {{WIDTH{b_el_s[WIDTH-1]}}, b_el_s};
  assign prod_s     = a_ext_s * b_ext_s;
  assign prod_ext_s = {{(ACC_W-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
`else
  assign a_ext_s    = {{WIDTH{1'b0}}, a_el_s};
  assign b_ext_s    = {{WIDTH{1'b0}}, b_el_s};
  assign prod_s     = a_ext_s * b_ext_s;
  assign prod_ext_s = {{(ACC_W-2*WIDTH){1'b0}}, prod_s};
`endif

  // Next-state and k-step decision for the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (idx == 4'b0000) begin
            state_nxt_s = ST_MAC;
            k_nxt_s     = 2'd0;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if ((k_r == 2'd0) && !op_ok_s) begin
          state_nxt_s = ST_ERR;
          k_nxt_s     = 2'd0;
        end else if (k_r == 2'd2) begin
          state_nxt_s = ST_WRITE;
          k_nxt_s     = 2'd0;
        end else begin
          state_nxt_s = ST_MAC;
          k_nxt_s     = k_r + 2'd1;
        end
      end
      ST_WRITE: begin
        if (idx == LAST_IDX) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ADV;
        end
      end
      ST_ADV: begin
        state_nxt_s = ST_MAC;
        k_nxt_s     = 2'd0;
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      ST_ERR: begin
        state_nxt_s = ST_ERR;
      end
      default: begin
        state_nxt_s = ST_ERR;
        k_nxt_s     = 2'd0;
      end
    endcase
  end

  // State and k-step registers.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_r <= ST_IDLE;
      k_r     <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
    end
  end

  // Status outputs are registered decodes of the state being entered.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      adv  <= 1'b0;
      c_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      adv  <= (state_nxt_s == ST_ADV);
      c_we <= (state_nxt_s == ST_WRITE);
      busy <= (state_nxt_s == ST_MAC) || (state_nxt_s == ST_WRITE) ||
              (state_nxt_s == ST_ADV);
      done <= (state_nxt_s == ST_DONE);
      err  <= (state_nxt_s == ST_ERR);
    end
  end

  // Multiply-accumulate, row/col capture and C bank write (lands the cycle after c_we).
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      acc_r <= {ACC_W{1'b0}};
      row_r <= 2'd0;
      col_r <= 2'd0;
      for (int i = 0; i < 9; i++) begin
        c_arr_r[i] <= {ACC_W{1'b0}};
      end
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        acc_r <= {ACC_W{1'b0}};
      end else if (state_r == ST_MAC) begin
        if (k_r == 2'd0) begin
          acc_r <= prod_ext_s;
          row_r <= idx[3:2];
          col_r <= idx[1:0];
        end else begin
          acc_r <= acc_r + prod_ext_s;
        end
      end
      if (state_r == ST_WRITE) begin
        c_arr_r[elem_pos(row_r, col_r)] <= acc_r;
      end
    end
  end

endmodule

// File: tb/tb_mm3_dot_sequencer.sv
// Directed self-checking bench for mm3_dot_sequencer with a behavioural
// 3x3 index counter driven by adv. Honors MM3_SIGNED_EN for the operand tests.
module tb_mm3_dot_sequencer;
  localparam int WIDTH = 8;
  localparam int ACC_W = 2*WIDTH+2;

  logic                 clk = 1'b0;
  logic                 mr;
  logic                 start;
  logic [3:0]           idx;
  logic [9*WIDTH-1:0]   a_flat;
  logic [9*WIDTH-1:0]   b_flat;
  logic                 adv;
  logic [9*ACC_W-1:0]   c_flat;
  logic                 c_we;
  logic                 busy;
  logic                 done;
  logic                 err;

  logic [3:0]           cnt;
  logic                 ovr_en;
  logic [3:0]           ovr_val;

  int errors = 0;
  int checks = 0;

  mm3_dot_sequencer #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .mr(mr), .start(start), .idx(idx),
    .a_flat(a_flat), .b_flat(b_flat),
    .adv(adv), .c_flat(c_flat), .c_we(c_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // 3x3 index counter: advances on the falling edge while adv is high.
  always @(negedge clk or posedge mr) begin
    if (mr) begin
      cnt <= 4'd0;
    end else if (adv) begin
      if (cnt[1:0] == 2'd2) cnt <= {cnt[3:2] + 2'd1, 2'd0};
      else                  cnt <= cnt + 4'd1;
    end
  end

  assign idx = ovr_en ? ovr_val : cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    mr = 1'b1;
    @(negedge clk);
    mr = 1'b0;
  endtask

  function automatic logic [63:0] c_el(input int i);
    return 64'(c_flat[i*ACC_W +: ACC_W]);
  endfunction

  // Pulse start and step negedges until done (bounded), counting strobes.
  task automatic run(output int edges, output int cwe_n, output int adv_n,
                     output int first_cwe, output int first_adv);
    edges = 0; cwe_n = 0; adv_n = 0; first_cwe = -1; first_adv = -1;
    start = 1'b1;
    @(negedge clk);
    edges = 1;
    start = 1'b0;
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
      if (c_we) begin cwe_n++; if (first_cwe < 0) first_cwe = edges; end
      if (adv)  begin adv_n++; if (first_adv < 0) first_adv = edges; end
    end
  endtask

  initial begin
    int edges, cwe_n, adv_n, f_cwe, f_adv, n;
    mr = 1'b1; start = 1'b0; ovr_en = 1'b0; ovr_val = 4'd0;
    a_flat = '0; b_flat = '0;
    @(negedge clk);
    @(negedge clk);
    // Reset state
    check("rst_adv", 64'(adv), 64'd0);
    check("rst_cwe", 64'(c_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cflat", 64'(c_flat == '0), 64'd1);
    mr = 1'b0;

    // Identity A, B = 1..9
    for (int i = 0; i < 9; i++) begin
      a_flat[i*WIDTH +: WIDTH] = (i % 4 == 0) ? 8'd1 : 8'd0;
      b_flat[i*WIDTH +: WIDTH] = 8'(i + 1);
    end
    run(edges, cwe_n, adv_n, f_cwe, f_adv);
    check("id_edges_to_done", 64'(edges), 64'd45);
    check("id_cwe_count", 64'(cwe_n), 64'd9);
    check("id_adv_count", 64'(adv_n), 64'd8);
    check("id_first_cwe", 64'(f_cwe), 64'd4);
    check("id_first_adv", 64'(f_adv), 64'd5);
    check("id_busy_done", 64'(busy), 64'd0);
    check("id_idx_held", 64'(idx), 64'd10);
    for (int i = 0; i < 9; i++) check($sformatf("id_c%0d", i), c_el(i), 64'(i + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("done_sticky", 64'(done), 64'd1);
    check("done_start_busy", 64'(busy), 64'd0);
    check("done_start_cwe", 64'(c_we), 64'd0);

`ifdef MM3_SIGNED_EN
    do_reset();
    a_flat = {9{8'h80}};
    b_flat = {9{8'h80}};
    run(edges, cwe_n, adv_n, f_cwe, f_adv);
    for (int i = 0; i < 9; i++) check($sformatf("neg128_c%0d", i), c_el(i), 64'd49152);
    do_reset();
    a_flat = {9{8'hFF}};
    for (int i = 0; i < 9; i++) b_flat[i*WIDTH +: WIDTH] = (i % 4 == 0) ? 8'd1 : 8'd0;
    run(edges, cwe_n, adv_n, f_cwe, f_adv);
    for (int i = 0; i < 9; i++) check($sformatf("negone_c%0d", i), c_el(i), 64'h3FFFF);
`else
    do_reset();
    a_flat = {9{8'hFF}};
    b_flat = {9{8'hFF}};
    run(edges, cwe_n, adv_n, f_cwe, f_adv);
    check("max_edges", 64'(edges), 64'd45);
    for (int i = 0; i < 9; i++) check($sformatf("max_c%0d", i), c_el(i), 64'd195075);
`endif

    // Reset mid-run at cycle 20
    do_reset();
    for (int i = 0; i < 9; i++) begin
      a_flat[i*WIDTH +: WIDTH] = (i % 4 == 0) ? 8'd1 : 8'd0;
      b_flat[i*WIDTH +: WIDTH] = 8'(i + 1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_busy_before", 64'(busy), 64'd1);
    check("mid_c2_before", c_el(2), 64'd3);
    mr = 1'b1;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_adv", 64'(adv), 64'd0);
    check("mid_cwe", 64'(c_we), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    check("mid_cflat", 64'(c_flat == '0), 64'd1);
    @(negedge clk);
    mr = 1'b0;
    run(edges, cwe_n, adv_n, f_cwe, f_adv);
    check("rerun_edges", 64'(edges), 64'd45);
    check("rerun_done", 64'(done), 64'd1);
    for (int i = 0; i < 9; i++) check($sformatf("rerun_c%0d", i), c_el(i), 64'(i + 1));

    // Start rejected with idx=0101
    do_reset();
    ovr_en = 1'b1; ovr_val = 4'b0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rej_err", 64'(err), 64'd1);
    check("rej_busy", 64'(busy), 64'd0);
    cwe_n = 0; adv_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (c_we) cwe_n++;
      if (adv) adv_n++;
    end
    check("rej_cwe_count", 64'(cwe_n), 64'd0);
    check("rej_adv_count", 64'(adv_n), 64'd0);
    check("rej_err_sticky", 64'(err), 64'd1);

    // Invalid index 0011 forced after the first adv
    ovr_en = 1'b0;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!adv && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("inv_first_adv_seen", 64'(adv), 64'd1);
    ovr_en = 1'b1; ovr_val = 4'b0011;
    cwe_n = 0; adv_n = 0;
    repeat (10) begin
      @(negedge clk);
      if (c_we) cwe_n++;
      if (adv) adv_n++;
    end
    check("inv_err", 64'(err), 64'd1);
    check("inv_busy", 64'(busy), 64'd0);
    check("inv_adv_after", 64'(adv_n), 64'd0);
    check("inv_cwe_after", 64'(cwe_n), 64'd0);
    check("inv_c0_kept", c_el(0), 64'd1);
    check("inv_c1_unwritten", c_el(1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
